riley_bus_ctrl: RTL and testbench
=================================

Name: riley_bus_ctrl

Overview:
- Parametrised memory-map controller between the 65C02 core and the system's memories and peripherals (SRAM, ROM, I/O).
- Decodes the CPU address bus into NUM_CS active-low chip selects and generates OE/WE strobes.
- Per-region wait states are inserted by pulling the CPU RDY low.
- Per-region read-only protection. Replaces hand-wired chip-select logic at the top level.

Parameters:
- ADDR_W, 16, CPU address width.
- NUM_CS, 4, number of decoded regions / chip selects.
- WS_W, 3, width of per-region wait-state count (0..2^WS_W-1).
- REGION_BASE, {16'h9000,16'hC000,16'h8000,16'h0000}, packed NUM_CS*ADDR_W base addresses; region i occupies slice i.
- REGION_MASK, {16'hF000,16'hC000,16'hFF00,16'h8000}, packed compare masks; hit_i = ((AB & MASK_i) == (BASE_i & MASK_i)).
- REGION_WS, {3'd3,3'd1,3'd2,3'd0}, packed wait states per region.
- REGION_RO, 4'b0100, bit i set = region i read-only.

Ports:
- CLOCK_IN  in  1  system clock, all state on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- AB  in  ADDR_W  CPU address.
- WE  in  1  CPU write enable, 1 = write cycle.
- EXT_RDY  in  1  external ready from slow devices, 1 = ready.
- RDY  out  1  ready to CPU.
- CS_N  out  NUM_CS  active-low chip selects.
- OE_N  out  1  active-low output enable.
- WE_N  out  1  active-low write strobe.
- SEL  out  clog2(NUM_CS)  index of the selected region (0 when none).
- HIT  out  1  1 when any region is selected.

Behaviour:
- Decode is combinational from AB. On overlapping hits, the lowest index wins. At most one CS_N bit is low.
- No hit: all CS_N high, OE_N high, WE_N high, HIT=0, no wait states.
- OE_N = !(HIT & !WE).
- WE_N = !(HIT & WE & !RO[SEL] & RDY). The strobe is driven only in the final (ready) cycle of an access, so it never spans a stall.
- Writes to a read-only region keep CS_N asserted, but WE_N stays high and the write is dropped silently.
- Wait-state FSM states:
  - IDLE: access start. If HIT and WS[SEL]=N>0: internal ready=0, cnt<=N-1, go to STALL. Otherwise internal ready=1 and stay in IDLE.
  - STALL: internal ready = (cnt==0). If cnt==0, go to IDLE; otherwise cnt<=cnt-1.
- An N-wait region access lasts exactly N+1 cycles, with RDY low for N cycles.
- RDY = internal ready & EXT_RDY.
- If EXT_RDY is low in the cycle the FSM would complete, the FSM holds in STALL with cnt=0 until EXT_RDY=1. RDY then rises that same cycle.
- The CPU holds AB and WE stable while RDY=0. The FSM does not re-sample the region during STALL; it uses the SEL latched at entry (sel_q) for WS and RO.
- Back-to-back accesses to wait-state regions re-enter STALL with no dead cycle.
- Reset (async, RESET=0): state=IDLE, cnt=0, sel_q=0. Outputs during and immediately after reset: RDY=EXT_RDY, WE_N=1, and CS_N/OE_N follow the decode of AB.
- Reset asserted mid-STALL aborts the stall immediately. No WE_N pulse is emitted.
- WS=0 regions are purely combinational: zero latency, no FSM transition.

Optional Feature:
- Macro RILEY_BUS_ERR_EN.
- When defined, the block adds:
  - Outputs BUS_ERR (1) and ERR_ADDR (ADDR_W).
  - Input ERR_CLR (1).
- An unmapped access (HIT=0), or a write to a read-only region, while RDY=1 sets sticky BUS_ERR on the next edge. ERR_ADDR captures AB of the first such event only; later errors do not overwrite it.
- ERR_CLR=1 clears BUS_ERR and re-arms capture. If ERR_CLR and a new error occur in the same cycle, the error wins: BUS_ERR stays 1 and ERR_ADDR takes the new address.
- Both outputs reset to 0. BUS_ERR is intended for the CPU IRQ line.
- When not defined, these ports and registers are absent and errors are ignored.

Test Plan:
- Read AB=16'h1234, WE=0 -> CS_N=4'b1110, OE_N=0, RDY=1 every cycle, SEL=0.
- Read AB=16'h8010 -> CS_N=4'b1101, RDY low exactly 2 cycles then high, OE_N low all 3 cycles, then next access starts.
- Write AB=16'hC000 (RO, WS=1) -> CS_N=4'b1011, RDY low 1 cycle, WE_N never low; with RILEY_BUS_ERR_EN, BUS_ERR=1 and ERR_ADDR=16'hC000.
- Write AB=16'h9000 with EXT_RDY held 0 for 5 extra cycles -> RDY low 3+5 cycles, WE_N low only in the single cycle RDY=1.
- Read AB=16'hA000 (unmapped) -> CS_N=4'hF, HIT=0, RDY=1; with RILEY_BUS_ERR_EN, BUS_ERR set; ERR_CLR pulse clears it.
- RESET pulled low in 2nd cycle of a 16'h9000 stall -> FSM IDLE immediately, RDY=EXT_RDY, no WE_N pulse, normal operation after release.

Source files
------------

// File: rtl/riley_bus_ctrl_if.sv
// CPU-side bus bundle for riley_bus_ctrl: address/strobe/ready handshake and decoded selects.
// The error-report signals exist only when RILEY_BUS_ERR_EN is defined.
interface riley_bus_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int NUM_CS = 4,
  parameter int SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
);
  logic [ADDR_W-1:0] ab;
  logic              we;
  logic              extRdy;
  logic              rdy;
  logic [NUM_CS-1:0] csN;
  logic              oeN;
  logic              weN;
  logic [SEL_W-1:0]  sel;
  logic              hit;
`ifdef RILEY_BUS_ERR_EN
  logic              errClr;
  logic              busErr;
  logic [ADDR_W-1:0] errAddr;
`endif

  // System side: drives the address and strobes, and sees the decoded outputs.
  modport master (
    output ab, we, extRdy,
`ifdef RILEY_BUS_ERR_EN
    output errClr,
    input  busErr, errAddr,
`endif
    input  rdy, csN, oeN, weN, sel, hit
  );

  modport slave (
    input  ab, we, extRdy,
`ifdef RILEY_BUS_ERR_EN
    input  errClr,
    output busErr, errAddr,
`endif
    output rdy, csN, oeN, weN, sel, hit
  );
endinterface

// File: rtl/riley_bus_ctrl.sv
// Memory-map controller for the 65C02: region decode, chip selects, OE/WE strobes and wait states.
// Optional bus-error capture is enabled by defining RILEY_BUS_ERR_EN.
module riley_bus_ctrl #(
  parameter int                       ADDR_W      = 16,
  parameter int                       NUM_CS      = 4,
  parameter int                       WS_W        = 3,
  parameter logic [NUM_CS*ADDR_W-1:0] REGION_BASE = {16'h9000, 16'hC000, 16'h8000, 16'h0000},
  parameter logic [NUM_CS*ADDR_W-1:0] REGION_MASK = {16'hF000, 16'hC000, 16'hFF00, 16'h8000},
  parameter logic [NUM_CS*WS_W-1:0]   REGION_WS   = {3'd3, 3'd1, 3'd2, 3'd0},
  parameter logic [NUM_CS-1:0]        REGION_RO   = 4'b0100
) (
  input logic          i_clk,
  input logic          i_rst_n,
  riley_bus_ctrl_if.slave bus
);

  localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_STALL
  } state_t;

  state_t            r_state;
  logic [WS_W-1:0]   r_cnt;
  logic [SEL_W-1:0]  r_selQ;

  logic              w_hit;
  logic [SEL_W-1:0]  w_sel;
  logic [SEL_W-1:0]  w_selEff;
  logic [WS_W-1:0]   w_wsNew;
  logic              w_ro;
  logic              w_intRdy;
  logic              w_rdy;
  logic [NUM_CS-1:0] w_csN;

  // Scanning from the top index down lets the lowest matching region win on overlap.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if ((bus.ab & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
          (REGION_BASE[i*ADDR_W +: ADDR_W] & REGION_MASK[i*ADDR_W +: ADDR_W])) begin
        w_hit = 1'b1;
        w_sel = SEL_W'(i);
      end
    end
  end

  always_comb begin
    w_csN = '1;
    if (w_hit) begin
      w_csN[w_sel] = 1'b0;
    end
  end

  assign w_wsNew  = REGION_WS[w_sel*WS_W +: WS_W];
  assign w_selEff = (r_state == ST_STALL) ? r_selQ : w_sel;
  assign w_ro     = REGION_RO[w_selEff];

  // Reset forces ready high so RDY simply mirrors EXT_RDY while the FSM is held.
  always_comb begin
    w_intRdy = 1'b1;
    if (i_rst_n) begin
      if (r_state == ST_STALL) begin
        w_intRdy = (r_cnt == '0);
      end else begin
        w_intRdy = !(w_hit && (w_wsNew != '0));
      end
    end
  end

  assign w_rdy   = w_intRdy & bus.extRdy;

  assign bus.rdy = w_rdy;
  assign bus.csN = w_csN;
  assign bus.sel = w_sel;
  assign bus.hit = w_hit;
  assign bus.oeN = !(w_hit && !bus.we);
  assign bus.weN = !(i_rst_n && w_hit && bus.we && !w_ro && w_rdy);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_selQ  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit && (w_wsNew != '0)) begin
            r_cnt   <= w_wsNew - 1'b1;
            r_selQ  <= w_sel;
            r_state <= ST_STALL;
          end
        end
        ST_STALL: begin
          // A slow device can extend the last wait cycle indefinitely.
          if (r_cnt == '0) begin
            if (bus.extRdy) begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef RILEY_BUS_ERR_EN
  logic              r_busErr;
  logic [ADDR_W-1:0] r_errAddr;
  logic              w_err;

  assign w_err = w_rdy && (!w_hit || (bus.we && w_ro));

  // Only the first error address is kept until software clears the flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busErr  <= 1'b0;
      r_errAddr <= '0;
    end else if (w_err) begin
      r_busErr <= 1'b1;
      if (!r_busErr || bus.errClr) begin
        r_errAddr <= bus.ab;
      end
    end else if (bus.errClr) begin
      r_busErr <= 1'b0;
    end
  end

  assign bus.busErr  = r_busErr;
  assign bus.errAddr = r_errAddr;
`endif

endmodule

// File: tb/tb_riley_bus_ctrl.sv
// Randomized self-checking bench for riley_bus_ctrl against a per-access region/latency model.
module tb_riley_bus_ctrl;

  localparam logic [15:0] T_BASE [4] = '{16'h0000, 16'h8000, 16'hC000, 16'h9000};
  localparam logic [15:0] T_MASK [4] = '{16'h8000, 16'hFF00, 16'hC000, 16'hF000};
  localparam int          T_WS   [4] = '{0, 2, 1, 3};
  localparam logic        T_RO   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rstN;
  int   testsRun = 0;
  int   testsFailed = 0;

`ifdef RILEY_BUS_ERR_EN
  logic        mBusErr = 1'b0;
  logic [15:0] mErrAddr = 16'h0000;
`endif

  riley_bus_ctrl_if #(.ADDR_W(16), .NUM_CS(4)) busIf ();

  riley_bus_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (busIf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int regionOf(input logic [15:0] a);
    for (int i = 0; i < 4; i++) begin
      if ((a & T_MASK[i]) == (T_BASE[i] & T_MASK[i])) return i;
    end
    return -1;
  endfunction

  // One complete CPU access; holdLow < 0 means random EXT_RDY and random ERR_CLR.
  task automatic applyStimulus(input logic [15:0] addr, input logic wr, input int holdLow, input logic clr);
    int          r;
    int          n;
    logic        ext;
    logic        rdyExp;
    logic        hitExp;
    logic        roExp;
    logic [3:0]  csExp;
    logic [1:0]  selExp;
    r      = regionOf(addr);
    hitExp = (r >= 0);
    n      = hitExp ? T_WS[r] : 0;
    selExp = hitExp ? r[1:0] : 2'd0;
    roExp  = hitExp ? T_RO[r] : 1'b0;
    csExp  = 4'hF;
    if (hitExp) csExp[r] = 1'b0;
    busIf.ab = addr;
    busIf.we = wr;
    for (int k = 0; k < 64; k++) begin
      if (holdLow < 0) ext = (k > n + 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
      else             ext = !(k >= n && k < n + holdLow);
      busIf.extRdy = ext;
`ifdef RILEY_BUS_ERR_EN
      busIf.errClr = (holdLow < 0) ? ($urandom_range(0, 7) == 0) : clr;
`endif
      rdyExp = (k >= n) && ext;
      @(negedge clk);
      checkOutput("rdy", busIf.rdy, rdyExp);
      checkOutput("csN", busIf.csN, csExp);
      checkOutput("oeN", busIf.oeN, !(hitExp && !wr));
      checkOutput("weN", busIf.weN, !(hitExp && wr && !roExp && rdyExp));
      checkOutput("sel", busIf.sel, selExp);
      checkOutput("hit", busIf.hit, hitExp);
`ifdef RILEY_BUS_ERR_EN
      checkOutput("busErr", busIf.busErr, mBusErr);
      checkOutput("errAddr", busIf.errAddr, mErrAddr);
`endif
      @(posedge clk);
`ifdef RILEY_BUS_ERR_EN
      if (rdyExp && (!hitExp || (wr && roExp))) begin
        if (!mBusErr || busIf.errClr) mErrAddr = addr;
        mBusErr = 1'b1;
      end else if (busIf.errClr) begin
        mBusErr = 1'b0;
      end
`endif
      #1;
      if (rdyExp) break;
    end
`ifdef RILEY_BUS_ERR_EN
    busIf.errClr = 1'b0;
`endif
    if (clr) begin end
  endtask

  initial begin
    logic [15:0] a;
    rstN         = 1'b0;
    busIf.ab     = 16'h1234;
    busIf.we     = 1'b0;
    busIf.extRdy = 1'b1;
`ifdef RILEY_BUS_ERR_EN
    busIf.errClr = 1'b0;
`endif
    #12;
    checkOutput("rstRdy", busIf.rdy, 1'b1);
    checkOutput("rstCsN", busIf.csN, 4'b1110);
    checkOutput("rstWeN", busIf.weN, 1'b1);
    busIf.ab = 16'h9000;
    busIf.we = 1'b1;
    #1;
    checkOutput("rstRdyWs", busIf.rdy, 1'b1);
    checkOutput("rstCsNWs", busIf.csN, 4'b0111);
    checkOutput("rstWeNWs", busIf.weN, 1'b1);
`ifdef RILEY_BUS_ERR_EN
    checkOutput("rstBusErr", busIf.busErr, 1'b0);
    checkOutput("rstErrAddr", busIf.errAddr, 16'h0000);
`endif
    busIf.ab = 16'h1234;
    busIf.we = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(16'h1234, 1'b0, 0, 1'b0);
    applyStimulus(16'h1234, 1'b0, 0, 1'b0);
    applyStimulus(16'h8010, 1'b0, 0, 1'b0);
    applyStimulus(16'hC000, 1'b1, 0, 1'b0);
    applyStimulus(16'h9000, 1'b1, 5, 1'b0);
    applyStimulus(16'hA000, 1'b0, 0, 1'b0);
    applyStimulus(16'h1234, 1'b0, 0, 1'b1);
    applyStimulus(16'h1234, 1'b0, 0, 1'b0);
    applyStimulus(16'h8020, 1'b1, 0, 1'b0);
    applyStimulus(16'h9FFF, 1'b0, 0, 1'b0);

    // Abort a 9000 stall with reset in its second cycle.
    busIf.ab     = 16'h9000;
    busIf.we     = 1'b1;
    busIf.extRdy = 1'b1;
    @(posedge clk);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("midRstRdy", busIf.rdy, 1'b1);
    checkOutput("midRstWeN", busIf.weN, 1'b1);
    checkOutput("midRstCsN", busIf.csN, 4'b0111);
    busIf.extRdy = 1'b0;
    #1;
    checkOutput("midRstRdyLow", busIf.rdy, 1'b0);
    busIf.extRdy = 1'b1;
    busIf.ab     = 16'h1234;
    busIf.we     = 1'b0;
`ifdef RILEY_BUS_ERR_EN
    mBusErr  = 1'b0;
    mErrAddr = 16'h0000;
`endif
    @(negedge clk);
    checkOutput("midRstWeNHeld", busIf.weN, 1'b1);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(16'h9000, 1'b1, 0, 1'b0);
    applyStimulus(16'h8000, 1'b1, 2, 1'b0);

    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        a = T_BASE[$urandom_range(0, 3)] | 16'($urandom_range(0, 255));
      end else begin
        a = 16'($urandom_range(0, 65535));
      end
      applyStimulus(a, 1'($urandom_range(0, 1)), -1, 1'b0);
    end
    applyStimulus(16'h0040, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
